// File: rtl/fifo_rd_stream_if.sv
// Signal bundle between the FIFO read port, the drain stage and the stream consumer.
// master = the drain stage; slave = the FIFO plus the consumer around it.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       buf_level;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output buf_level,
    output xfer_count
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  buf_level,
    input  xfer_count
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: turns the FIFO pop/empty port (1-cycle read latency)
// into a valid/ready stream through a 2-entry prefetch buffer.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic           rd_clk,
  input  logic           rd_rst_n,
  fifo_rd_stream_if.master bus
);

  logic [1:0]       level;
  logic             pend;
  logic             head;
  logic             tail;
  logic [WIDTH-1:0] buf_mem [2];
  logic [CNT_W-1:0] xfer_cnt;

  logic             take;
  logic             pop;
  logic [2:0]       occ_next;

  // A pop is allowed only if the word it returns is guaranteed a free slot,
  // counting the word already in flight and the one leaving this cycle.
  always_comb begin
    take     = (level != 2'd0) & bus.m_ready;
    occ_next = {1'b0, level} + {2'b00, pend} - {2'b00, take};
    pop      = rd_rst_n & ~bus.fifo_empty & (occ_next < 3'd2);
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      level      <= 2'd0;
      pend       <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      xfer_cnt   <= '0;
    end else begin
      pend <= pop;
      if (pend) begin
        buf_mem[tail] <= bus.fifo_rd_data;
        tail          <= ~tail;
      end
      if (take) begin
        head     <= ~head;
        xfer_cnt <= xfer_cnt + 1'b1;
      end
      level <= level + {1'b0, pend} - {1'b0, take};
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.m_valid    = (level != 2'd0);
  assign bus.m_data     = buf_mem[head];
  assign bus.buf_level  = level;
  assign bus.xfer_count = xfer_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO and consumer modelled with queues; directed
// table, hand sequences and randomized traffic checked against a queue model.
module tb_fifo_rd_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic rd_clk = 1'b0;
  logic rd_rst_n;

  fifo_rd_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus)
  );

  always #5 rd_clk = ~rd_clk;

  int n_vec  = 0;
  int n_miss = 0;

  // bench-side FIFO and scoreboard
  logic [7:0] fifo_q [$];
  logic [7:0] sq [$];
  logic [7:0] rd_data_q;

  // reference model: buffered words in order, one in-flight flag
  logic [7:0] mb [$];
  bit         mp;
  int         cnt;
  bit         zr;
  int         n_take;

  // outputs sampled in the last cycle
  logic       a_en, a_vld;
  logic [7:0] a_dat;
  logic [1:0] a_lvl;
  logic [3:0] a_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    sq.push_back(w);
  endtask

  task automatic cycle(input bit rst_v, input bit rdy_v, input bit stall_v);
    bit   fe, e_vld, e_take, e_en;
    int   occ;
    rd_rst_n        = rst_v;
    bus.m_ready     = rdy_v;
    fe              = stall_v | (fifo_q.size() == 0);
    bus.fifo_empty  = fe;
    bus.fifo_rd_data = rd_data_q;
    @(negedge rd_clk);
    a_en  = bus.fifo_rd_en;
    a_vld = bus.m_valid;
    a_dat = bus.m_data;
    a_lvl = bus.buf_level;
    a_cnt = bus.xfer_count;
    e_vld  = (mb.size() != 0);
    e_take = e_vld & rdy_v;
    occ    = mb.size() + int'(mp) - int'(e_take);
    e_en   = rst_v & ~fe & (occ < 2);
    chk("fifo_rd_en", 32'(a_en), 32'(e_en));
    chk("m_valid", 32'(a_vld), 32'(e_vld));
    chk("buf_level", 32'(a_lvl), 32'(mb.size()));
    chk("xfer_count", 32'(a_cnt), 32'(cnt));
    if (e_vld) chk("m_data", 32'(a_dat), 32'(mb[0]));
    else if (zr) chk("m_data_rst", 32'(a_dat), 32'h0);
    chk("level_plus_pend", 32'(int'(u_dut.level) + int'(u_dut.pend) <= 2), 32'h1);
    @(posedge rd_clk);
    #1;
    if (!rst_v) begin
      mb.delete();
      mp = 1'b0;
      cnt = 0;
      zr = 1'b1;
      n_take = 0;
      fifo_q.delete();
      sq.delete();
      rd_data_q = '0;
    end else begin
      if (e_take) begin
        if (sq.size() == 0) chk("order_underrun", 32'(a_dat), 32'hFFFF);
        else chk("order", 32'(a_dat), 32'(sq.pop_front()));
        void'(mb.pop_front());
        cnt = (cnt + 1) % (1 << CNT_W);
        n_take++;
      end
      if (mp) begin
        mb.push_back(rd_data_q);
        zr = 1'b0;
      end
      mp = e_en;
      if (a_en) rd_data_q = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'hEE;
    end
    bus.fifo_rd_data = rd_data_q;
  endtask

  typedef struct {
    bit         en;
    bit         vld;
    logic [7:0] dat;
    logic [1:0] lvl;
    logic [3:0] xc;
  } vec_t;

  vec_t tbl [6];
  int   pops, vcnt, budget;

  initial begin
    // expected cycles t..t+5 for FIFO {11,22,33} drained with m_ready=1
    tbl[0] = '{en:1'b1, vld:1'b0, dat:8'h00, lvl:2'd0, xc:4'd0};
    tbl[1] = '{en:1'b1, vld:1'b0, dat:8'h00, lvl:2'd0, xc:4'd0};
    tbl[2] = '{en:1'b1, vld:1'b1, dat:8'h11, lvl:2'd1, xc:4'd0};
    tbl[3] = '{en:1'b0, vld:1'b1, dat:8'h22, lvl:2'd1, xc:4'd1};
    tbl[4] = '{en:1'b0, vld:1'b1, dat:8'h33, lvl:2'd1, xc:4'd2};
    tbl[5] = '{en:1'b0, vld:1'b0, dat:8'h00, lvl:2'd0, xc:4'd3};

    rd_rst_n = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    rd_data_q = '0;
    bus.fifo_rd_data = '0;
    mp = 1'b0; cnt = 0; zr = 1'b1; n_take = 0;
    repeat (2) @(posedge rd_clk);
    #1;

    // reset held with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      push(8'h5A);
      cycle(1'b0, 1'b1, 1'b0);
      chk("rst_no_pop", 32'(a_en), 32'h0);
    end

    // table: three words, consumer always ready
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_en", i), 32'(a_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_vld", i), 32'(a_vld), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl%0d_dat", i), 32'(a_dat), 32'(tbl[i].dat));
      chk($sformatf("tbl%0d_lvl", i), 32'(a_lvl), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].xc));
    end

    // back-pressure: exactly two pops fill the buffer, then a full-rate drain
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      pops += int'(a_en);
    end
    chk("bp_pops", 32'(pops), 32'd2);
    chk("bp_level", 32'(a_lvl), 32'd2);
    chk("bp_no_pop", 32'(a_en), 32'd0);
    chk("bp_head", 32'(a_dat), 32'hA0);
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      vcnt += int'(a_vld);
    end
    chk("bp_full_rate", 32'(vcnt), 32'd5);
    cycle(1'b1, 1'b1, 1'b0);
    chk("bp_drained", 32'(a_lvl), 32'd0);

    // alternating ready over 20 words
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) push(8'(i));
    budget = 0;
    while (n_take < 20 && budget < 200) begin
      cycle(1'b1, budget[0] == 1'b0, 1'b0);
      budget++;
    end
    chk("alt_takes", 32'(n_take), 32'd20);
    cycle(1'b1, 1'b0, 1'b0);
    chk("alt_count", 32'(a_cnt), 32'd4);

    // random empty stalls against random ready
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) push(8'($urandom));
    budget = 0;
    while (n_take < 1000 && budget < 20000) begin
      cycle(1'b1, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      budget++;
    end
    chk("rand_takes", 32'(n_take), 32'd1000);
    chk("rand_sb_empty", 32'(sq.size()), 32'd0);

    // reset while the buffer is full and more words wait in the FIFO
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("prerst_level", 32'(a_lvl), 32'd2);
    cycle(1'b1, 1'b0, 1'b0);
    chk("rst_valid", 32'(a_vld), 32'd0);
    chk("rst_level", 32'(a_lvl), 32'd0);
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_data", 32'(a_dat), 32'd0);

    // counter wrap: 17 transfers modulo 16
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    budget = 0;
    while (n_take < 17 && budget < 200) begin
      cycle(1'b1, 1'b1, 1'b0);
      budget++;
    end
    chk("wrap_takes", 32'(n_take), 32'd17);
    cycle(1'b1, 1'b1, 1'b0);
    chk("wrap_count", 32'(a_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
